// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, coordinate widths and the control bundle that
// travels alongside the renderer pipeline.
package vga_pkg;

    localparam int H_W = 11;
    localparam int V_W = 10;

    localparam int DEF_H_PIXELS = 800;
    localparam int DEF_H_FRONT  = 40;
    localparam int DEF_H_SYNC   = 128;
    localparam int DEF_H_BACK   = 88;
    localparam int DEF_V_PIXELS = 600;
    localparam int DEF_V_FRONT  = 1;
    localparam int DEF_V_SYNC   = 4;
    localparam int DEF_V_BACK   = 23;

    localparam int DEF_H_TOTAL    = DEF_H_PIXELS + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int DEF_V_TOTAL    = DEF_V_PIXELS + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;
    localparam int DEF_HS_START   = DEF_H_PIXELS + DEF_H_FRONT;
    localparam int DEF_HS_END     = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START   = DEF_V_PIXELS + DEF_V_FRONT;
    localparam int DEF_VS_END     = DEF_VS_START + DEF_V_SYNC;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } vga_ctrl_t;

    // Raw (polarity-free) idle state: no sync pulse, blanked.
    localparam vga_ctrl_t CTRL_IDLE = '{hs: 1'b0, vs: 1'b0, de: 1'b0};

endpackage

// File: rtl/vga_delay_line.sv
// Generic DEPTH x WIDTH shift register with async reset to RESET_VAL.
// DEPTH = 0 is a plain wire so callers can tune latency down to nothing.
module vga_delay_line #(
    parameter int               DEPTH     = 1,
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stages [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stages[i] <= RESET_VAL;
                end else begin
                    stages[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
                end
            end

            assign q = stages[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA scan generator and pin output stage: raw h/v counters for renderers,
// with sync/blank re-aligned to the renderer's RGB latency at the pins.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int   H_PIXELS    = DEF_H_PIXELS,
    parameter int   H_FRONT     = DEF_H_FRONT,
    parameter int   H_SYNC      = DEF_H_SYNC,
    parameter int   H_BACK      = DEF_H_BACK,
    parameter int   V_PIXELS    = DEF_V_PIXELS,
    parameter int   V_FRONT     = DEF_V_FRONT,
    parameter int   V_SYNC      = DEF_V_SYNC,
    parameter int   V_BACK      = DEF_V_BACK,
    parameter logic H_POL       = 1'b1,
    parameter logic V_POL       = 1'b1,
    parameter int   RGB_LATENCY = 1
) (
    input  logic             pixel_clk,
    input  logic             rst_n,
    output logic [H_W-1:0]   h_coord,
    output logic [V_W-1:0]   v_coord,
    output logic             display_on,
    output logic             end_of_frame,
    output logic [15:0]      frame_cnt,
    input  logic [3:0]       rgb_r_in,
    input  logic [3:0]       rgb_g_in,
    input  logic [3:0]       rgb_b_in,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b,
    output logic             vga_hs,
    output logic             vga_vs
);

    localparam int H_TOTAL  = H_PIXELS + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_PIXELS + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_PIXELS + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_PIXELS + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    generate
        if (H_TOTAL > 2048 || V_TOTAL > 1024 || RGB_LATENCY > 4 || RGB_LATENCY < 0) begin : g_bad_params
            $error("vga_timing_gen: unsupported timing parameters");
        end
    endgenerate

    logic [1:0] rst_sync;
    logic       rst_int_n;
    logic       started;
    logic       h_wrap;
    logic       v_wrap;
    vga_ctrl_t  ctrl_raw;
    vga_ctrl_t  ctrl_dly;

    // Assert asynchronously, release two clocks later in step with pixel_clk.
    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_int_n = rst_sync[1];

    assign h_wrap = (int'(h_coord) == H_TOTAL - 1);
    assign v_wrap = (int'(v_coord) == V_TOTAL - 1);

    // The first clock after release only arms 'started', so (0,0) is shown
    // for a full clock and the first line after reset is complete.
    always_ff @(posedge pixel_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            started   <= 1'b0;
            h_coord   <= '0;
            v_coord   <= '0;
            frame_cnt <= '0;
        end else if (!started) begin
            started <= 1'b1;
        end else begin
            if (h_wrap) begin
                h_coord <= '0;
                v_coord <= v_wrap ? '0 : v_coord + 1'b1;
            end else begin
                h_coord <= h_coord + 1'b1;
            end
            if (h_wrap && v_wrap) frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign display_on   = started && (int'(h_coord) < H_PIXELS) && (int'(v_coord) < V_PIXELS);
    assign end_of_frame = started && (int'(h_coord) == H_PIXELS - 1) && (int'(v_coord) == V_PIXELS - 1);

    assign ctrl_raw.hs = (int'(h_coord) >= HS_START) && (int'(h_coord) < HS_END);
    assign ctrl_raw.vs = (int'(v_coord) >= VS_START) && (int'(v_coord) < VS_END);
    assign ctrl_raw.de = display_on;

    vga_delay_line #(
        .DEPTH     (RGB_LATENCY),
        .WIDTH     ($bits(vga_ctrl_t)),
        .RESET_VAL (CTRL_IDLE)
    ) u_ctrl_dly (
        .clk   (pixel_clk),
        .rst_n (rst_int_n),
        .d     (ctrl_raw),
        .q     (ctrl_dly)
    );

    always_ff @(posedge pixel_clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= ~H_POL;
            vga_vs <= ~V_POL;
        end else begin
            vga_r  <= ctrl_dly.de ? rgb_r_in : 4'h0;
            vga_g  <= ctrl_dly.de ? rgb_g_in : 4'h0;
            vga_b  <= ctrl_dly.de ? rgb_b_in : 4'h0;
            vga_hs <= ctrl_dly.hs ~^ H_POL;
            vga_vs <= ctrl_dly.vs ~^ V_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two shrunken-timing instances and
// one at default timing, each checked against an independent scan model.
module tb_vga_timing_gen;

    localparam int   HP  [3] = '{16, 16, 800};
    localparam int   HF  [3] = '{2, 2, 40};
    localparam int   HSW [3] = '{3, 3, 128};
    localparam int   HB  [3] = '{2, 2, 88};
    localparam int   VP  [3] = '{6, 6, 600};
    localparam int   VF  [3] = '{1, 1, 1};
    localparam int   VSW [3] = '{2, 2, 4};
    localparam int   VB  [3] = '{2, 2, 23};
    localparam int   LAT [3] = '{1, 3, 1};
    localparam logic POL [3] = '{1'b1, 1'b0, 1'b1};

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
    } pin_t;

    logic        clk = 1'b0;
    logic        rst_n [3];
    logic [10:0] h_c   [3];
    logic [9:0]  v_c   [3];
    logic        de_c  [3];
    logic        eof_c [3];
    logic [15:0] fc_c  [3];
    logic [3:0]  r_c   [3];
    logic [3:0]  g_c   [3];
    logic [3:0]  b_c   [3];
    logic        hs_c  [3];
    logic        vs_c  [3];
    logic [3:0]  rgb_r = 4'h0;
    logic [3:0]  rgb_g = 4'h0;
    logic [3:0]  rgb_b = 4'h0;

    int   tests_run    = 0;
    int   tests_failed = 0;
    pin_t sbq[$];
    int   mh, mv, mfc;
    int   st_eof, st_first_colour, st_colour, st_line_len;
    int   st_hs_first, st_hs_width, st_vs_first, st_vs_width;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 3; k++) begin : g_dut
        vga_timing_gen #(
            .H_PIXELS(HP[k]), .H_FRONT(HF[k]), .H_SYNC(HSW[k]), .H_BACK(HB[k]),
            .V_PIXELS(VP[k]), .V_FRONT(VF[k]), .V_SYNC(VSW[k]), .V_BACK(VB[k]),
            .H_POL(POL[k]), .V_POL(POL[k]), .RGB_LATENCY(LAT[k])
        ) dut (
            .pixel_clk    (clk),
            .rst_n        (rst_n[k]),
            .h_coord      (h_c[k]),
            .v_coord      (v_c[k]),
            .display_on   (de_c[k]),
            .end_of_frame (eof_c[k]),
            .frame_cnt    (fc_c[k]),
            .rgb_r_in     (rgb_r),
            .rgb_g_in     (rgb_g),
            .rgb_b_in     (rgb_b),
            .vga_r        (r_c[k]),
            .vga_g        (g_c[k]),
            .vga_b        (b_c[k]),
            .vga_hs       (hs_c[k]),
            .vga_vs       (vs_c[k])
        );
    end

    function automatic logic [11:0] pat(input int t, input bit solid);
        return solid ? 12'hFFF : 12'(t * 37 + 5);
    endfunction

    // Checks a DUT sits at its reset values (called during or right after reset).
    task automatic check_reset_values(input int k, input string name);
        tests_run++;
        if (h_c[k] !== 11'd0 || v_c[k] !== 10'd0 || fc_c[k] !== 16'd0 || de_c[k] !== 1'b0 ||
            eof_c[k] !== 1'b0 || {r_c[k], g_c[k], b_c[k]} !== 12'h000 ||
            hs_c[k] !== ~POL[k] || vs_c[k] !== ~POL[k]) begin
            tests_failed++;
            $display("[TB] FAIL %s dut%0d: got h=%0d v=%0d fc=%0d de=%b eof=%b rgb=%h hs=%b vs=%b, expected zeros with hs=vs=%b",
                     name, k, h_c[k], v_c[k], fc_c[k], de_c[k], eof_c[k], {r_c[k], g_c[k], b_c[k]},
                     hs_c[k], vs_c[k], ~POL[k]);
        end
    endtask

    // Waits (bounded) for display_on after release; expects 3 clocks of startup.
    task automatic wait_start(input int k);
        int n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (de_c[k] === 1'b1) begin
                n = i;
                break;
            end
        end
        tests_run++;
        if (n != 3) begin
            tests_failed++;
            $display("[TB] FAIL start_latency dut%0d: got %0d clocks, expected 3", k, n);
        end
        mh = 0;
        mv = 0;
        mfc = 0;
        sbq.delete();
    endtask

    task automatic start_dut(input int k);
        rst_n[k] = 1'b0;
        @(negedge clk);
        rst_n[k] = 1'b1;
        wait_start(k);
    endtask

    // Runs the scan model; expected pins are queued per coordinate and popped
    // LAT+1 clocks later when they should appear on the pins.
    task automatic run_sb(input int k, input int ncycles, input bit solid);
        int ht = HP[k] + HF[k] + HSW[k] + HB[k];
        int vt = VP[k] + VF[k] + VSW[k] + VB[k];
        logic exp_de, exp_eof, hs_raw, vs_raw, hs_act, vs_act;
        bit hs_done = 0, vs_done = 0;
        logic [11:0] c;
        pin_t e, o, got;
        st_eof = 0; st_first_colour = -1; st_colour = 0; st_line_len = -1;
        st_hs_first = -1; st_hs_width = 0; st_vs_first = -1; st_vs_width = 0;
        for (int t = 0; t < ncycles; t++) begin
            exp_de  = (mh < HP[k]) && (mv < VP[k]);
            exp_eof = (mh == HP[k] - 1) && (mv == VP[k] - 1);
            tests_run++;
            if (h_c[k] !== 11'(mh) || v_c[k] !== 10'(mv) || de_c[k] !== exp_de ||
                eof_c[k] !== exp_eof || fc_c[k] !== 16'(mfc)) begin
                tests_failed++;
                $display("[TB] FAIL coord dut%0d t=%0d: got h=%0d v=%0d de=%b eof=%b fc=%0d, expected h=%0d v=%0d de=%b eof=%b fc=%0d",
                         k, t, h_c[k], v_c[k], de_c[k], eof_c[k], fc_c[k], mh, mv, exp_de, exp_eof, mfc);
            end
            hs_raw = (mh >= HP[k] + HF[k]) && (mh < HP[k] + HF[k] + HSW[k]);
            vs_raw = (mv >= VP[k] + VF[k]) && (mv < VP[k] + VF[k] + VSW[k]);
            c = pat(t + LAT[k], solid);
            e.r  = exp_de ? c[11:8] : 4'h0;
            e.g  = exp_de ? c[7:4]  : 4'h0;
            e.b  = exp_de ? c[3:0]  : 4'h0;
            e.hs = hs_raw ? POL[k] : ~POL[k];
            e.vs = vs_raw ? POL[k] : ~POL[k];
            sbq.push_back(e);
            if (sbq.size() > LAT[k] + 1) begin
                o = sbq.pop_front();
                got = {r_c[k], g_c[k], b_c[k], hs_c[k], vs_c[k]};
                tests_run++;
                if (got !== o) begin
                    tests_failed++;
                    $display("[TB] FAIL pins dut%0d t=%0d: got rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
                             k, t, {got.r, got.g, got.b}, got.hs, got.vs, {o.r, o.g, o.b}, o.hs, o.vs);
                end
            end
            if (eof_c[k] === 1'b1) st_eof++;
            if (st_first_colour < 0 && r_c[k] !== 4'h0) st_first_colour = t;
            if ({r_c[k], g_c[k], b_c[k]} === 12'hFFF) st_colour++;
            if (st_line_len < 0 && t > 0 && h_c[k] === 11'd0) st_line_len = t;
            hs_act = (hs_c[k] === POL[k]);
            if (hs_act && !hs_done) begin
                if (st_hs_first < 0) st_hs_first = t;
                st_hs_width++;
            end else if (!hs_act && st_hs_first >= 0) hs_done = 1;
            vs_act = (vs_c[k] === POL[k]);
            if (vs_act && !vs_done) begin
                if (st_vs_first < 0) st_vs_first = t;
                st_vs_width++;
            end else if (!vs_act && st_vs_first >= 0) vs_done = 1;
            c = pat(t, solid);
            rgb_r = c[11:8];
            rgb_g = c[7:4];
            rgb_b = c[3:0];
            if (mh == ht - 1) begin
                mh = 0;
                if (mv == vt - 1) begin
                    mv = 0;
                    mfc = (mfc + 1) & 16'hFFFF;
                end else mv++;
            end else mh++;
            @(negedge clk);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests_run++;
        if (got != exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) check_reset_values(k, "reset_state");
    endtask

    task automatic test_frames();
        start_dut(0);
        run_sb(0, 2 * 253 + 1, 1'b0);
        check_int("frame_cnt_after_2_frames", int'(fc_c[0]), 2);
        check_int("eof_pulses_2_frames", st_eof, 2);
        check_int("line_length_small", st_line_len, 23);
    endtask

    task automatic test_colour_and_sync();
        start_dut(0);
        run_sb(0, 255, 1'b1);
        check_int("active_pixels_per_frame", st_colour, 96);
        check_int("first_colour_clock", st_first_colour, 2);
        check_int("hs_first_active", st_hs_first, 20);
        check_int("hs_width", st_hs_width, 3);
        check_int("vs_first_active", st_vs_first, 163);
        check_int("vs_width_2_lines", st_vs_width, 46);
    endtask

    task automatic test_mid_reset();
        start_dut(0);
        run_sb(0, 3 * 23 + 8, 1'b0);
        #2;
        rst_n[0] = 1'b0;
        #1;
        check_reset_values(0, "async_reset_mid_frame");
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        wait_start(0);
        run_sb(0, 253 + 5, 1'b0);
        check_int("line_length_after_reset", st_line_len, 23);
    endtask

    task automatic test_latency3_neg_pol();
        start_dut(1);
        run_sb(1, 2 * 253 + 3, 1'b1);
        check_int("lat3_first_colour", st_first_colour, 4);
        check_int("lat3_hs_first_low", st_hs_first, 22);
        check_int("lat3_hs_width", st_hs_width, 3);
        check_int("lat3_vs_first_low", st_vs_first, 165);
        check_int("lat3_vs_width", st_vs_width, 46);
        check_int("lat3_frame_cnt", int'(fc_c[1]), 2);
    endtask

    task automatic test_default_line();
        start_dut(2);
        run_sb(2, 2 * 1056, 1'b1);
        check_int("def_hs_first_active", st_hs_first, 842);
        check_int("def_hs_width", st_hs_width, 128);
        check_int("def_line_length", st_line_len, 1056);
        check_int("def_active_pixels_2_lines", st_colour, 1600);
        check_int("def_first_colour", st_first_colour, 2);
    endtask

    initial begin
        test_reset();
        test_frames();
        test_colour_and_sync();
        test_mid_reset();
        test_latency3_neg_pol();
        test_default_line();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
